// File: rtl/alu_pkg.sv
// Shared definitions for the sequential 5-bit right-shift unit.
package alu_pkg;
  localparam int ALU_W     = 5;
  localparam int SHAMT_W   = 3;
  localparam int MAX_SHIFT = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/alu_shr_seq_5bit.sv
// Sequential right shifter: one bit per clock, logical or arithmetic,
// with carry = last bit shifted out and a one-cycle done pulse.
module alu_shr_seq_5bit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             arith,
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  output logic [ALU_W-1:0] R,
  output logic             CF,
  output logic             busy,
  output logic             done
);

  localparam logic [SHAMT_W-1:0] MAX_AMT = SHAMT_W'(MAX_SHIFT);

  state_e             state_q, state_d;
  logic [ALU_W-1:0]   r_q, r_d;
  logic               cf_q, cf_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               arith_q, arith_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] amt_s;
  logic               fill_s;
  logic               unused_b_s;

  assign amt_s      = B[SHAMT_W-1:0];
  assign unused_b_s = ^B[ALU_W-1:SHAMT_W];
  // The sign bit never changes during an arithmetic shift, so it is its own fill.
  assign fill_s     = arith_q & r_q[ALU_W-1];

  // Next-state, datapath and counter logic.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cf_d    = cf_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          arith_d = arith;
          cf_d    = 1'b0;
          cnt_d   = amt_s;
          if (amt_s == {SHAMT_W{1'b0}}) begin
            r_d     = A;
            state_d = DONE;
          end else if (amt_s > MAX_AMT) begin
            r_d     = {ALU_W{arith & A[ALU_W-1]}};
            cnt_d   = {SHAMT_W{1'b0}};
            state_d = DONE;
          end else begin
            r_d     = A;
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        r_d   = {fill_s, r_q[ALU_W-1:1]};
        cf_d  = r_q[0];
        cnt_d = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, operand, counter and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= {ALU_W{1'b0}};
      cf_q    <= 1'b0;
      cnt_q   <= {SHAMT_W{1'b0}};
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cf_q    <= cf_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign R    = r_q;
  assign CF   = cf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu_shr_seq_5bit.sv
// Directed self-checking bench for alu_shr_seq_5bit.
module tb_alu_shr_seq_5bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       arith;
  logic [4:0] A;
  logic [4:0] B;
  logic [4:0] R;
  logic       CF;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  alu_shr_seq_5bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .arith (arith),
    .A     (A),
    .B     (B),
    .R     (R),
    .CF    (CF),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Start an operation, measure latency to done, check result, then check hold in IDLE.
  task automatic run_op(input string tag, input logic [4:0] a, input logic [4:0] b,
                        input logic ar, input logic [4:0] er, input logic ecf,
                        input int elat, input logic disturb);
    int n;
    int extra;
    A = a; B = b; arith = ar; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    if (disturb) begin
      start = 1'b1; A = 5'b11111; B = 5'b00001; arith = 1'b1;
    end
    while (!done && n < 20) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk({tag, "_lat"},  n,    elat);
    chk({tag, "_R"},    R,    er);
    chk({tag, "_CF"},   CF,   ecf);
    chk({tag, "_busy"}, busy, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_done_low"}, done, 1'b0);
    chk({tag, "_idle"},     busy, 1'b0);
    chk({tag, "_R_hold"},   R,    er);
    chk({tag, "_CF_hold"},  CF,   ecf);
    if (disturb) begin
      extra = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      chk({tag, "_no_extra_done"}, extra, 0);
      chk({tag, "_R_final"}, R, er);
    end
  endtask

  initial begin
    int pulses;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; start = 1'b0; arith = 1'b0; A = 5'd0; B = 5'd0;
    #12;
    chk("rst_R",    R,    5'b00000);
    chk("rst_CF",   CF,   1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First start right after reset release; subsequent calls run back-to-back.
    run_op("lsr2",  5'b10110, 5'b00010, 1'b0, 5'b00101, 1'b1, 3, 1'b0);
    run_op("asr3",  5'b10110, 5'b00011, 1'b1, 5'b11110, 1'b1, 4, 1'b0);
    run_op("amt0",  5'b01101, 5'b00000, 1'b0, 5'b01101, 1'b0, 1, 1'b0);
    run_op("asr7",  5'b10000, 5'b00111, 1'b1, 5'b11111, 1'b0, 1, 1'b0);
    run_op("lsr7",  5'b10000, 5'b00111, 1'b0, 5'b00000, 1'b0, 1, 1'b0);
    run_op("lsr6",  5'b11010, 5'b01110, 1'b0, 5'b00000, 1'b0, 1, 1'b0);
    run_op("asr6",  5'b11010, 5'b11110, 1'b1, 5'b11111, 1'b0, 1, 1'b0);
    // Last bit out for amt=5 is A[4].
    run_op("lsr5",  5'b00001, 5'b00101, 1'b0, 5'b00000, 1'b0, 6, 1'b1);
    run_op("asr5",  5'b10001, 5'b00101, 1'b1, 5'b11111, 1'b1, 6, 1'b0);
    run_op("lsr1",  5'b01011, 5'b00001, 1'b0, 5'b00101, 1'b1, 2, 1'b0);
    run_op("asr4p", 5'b01000, 5'b00100, 1'b1, 5'b00000, 1'b1, 5, 1'b0);

    // Reset in the middle of a shift.
    A = 5'b11111; B = 5'b00100; arith = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_R",    R,    5'b00000);
    chk("mid_rst_CF",   CF,   1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("mid_rst_quiet", pulses, 0);
    run_op("post_rst_a", 5'b11111, 5'b00100, 1'b1, 5'b11111, 1'b1, 5, 1'b0);
    run_op("post_rst_l", 5'b11111, 5'b00100, 1'b0, 5'b00001, 1'b1, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
